fft_ibut_comp_ser: RTL and testbench

Streaming radix-4 inverse complex butterfly for the IFFT path. It accepts one complex sample per cycle over a valid/ready handshake and collects groups of four. For each group it computes the 4-point inverse DFT (conjugate twiddles ±j) and streams the four results out serially. It undoes the forward `fft_but_comp` stage, which scales by 1/4 with rounding, so this block applies no scaling and limits the output to BIT bits.

---
 rtl/fft_pkg.sv | 39 +++
 rtl/fft_ibut_core.sv | 46 ++++
 rtl/fft_ibut_comp_ser.sv | 95 +++++++++
 tb/tb_fft_ibut_comp_ser.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: sample width, complex sample type, limiting helpers.
// Macro FFT_IBUT_SAT_EN (default undefined): when defined, the inverse butterfly saturates
// out-of-range results; otherwise it keeps the low BIT bits (wrap).
package fft_pkg;

    localparam int BIT  = 17;
    localparam int WBIT = BIT + 2;

    typedef logic signed [BIT-1:0]  comp_t;
    typedef logic signed [WBIT-1:0] wide_t;

    typedef struct packed {
        comp_t re;
        comp_t im;
    } sample_t;

    localparam wide_t SMAX = wide_t'((2 ** (BIT - 1)) - 1);
    localparam wide_t SMIN = wide_t'(-(2 ** (BIT - 1)));

    // True when a widened sum does not fit the BIT-wide signed range.
    function automatic logic out_of_range(input wide_t v);
        return (v > SMAX) || (v < SMIN);
    endfunction

    // Reduce a widened sum to BIT bits, either clamping or wrapping.
    function automatic comp_t limit(input wide_t v);
`ifdef FFT_IBUT_SAT_EN
        if (v > SMAX)
            return SMAX[BIT-1:0];
        else if (v < SMIN)
            return SMIN[BIT-1:0];
        else
            return v[BIT-1:0];
`else
        return v[BIT-1:0];
`endif
    endfunction

endpackage

// File: rtl/fft_ibut_core.sv
// Purely combinational 4-point inverse DFT kernel (twiddles +/-j), unscaled, with limiting.
// Latency: 0 cycles. Backpressure: none, pure function of the input bank.
// Limiting mode follows FFT_IBUT_SAT_EN (saturate) or wraps by default; overflow flag is the same either way.
module fft_ibut_core
    import fft_pkg::*;
(
    input  sample_t    i_x [4],
    output sample_t    o_y [4],
    output logic [3:0] o_ovf
);

    wide_t w_xr [4];
    wide_t w_xi [4];
    wide_t w_yr [4];
    wide_t w_yi [4];

    // Sign-extend inputs so no partial sum can overflow.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_xr[n] = wide_t'($signed(i_x[n].re));
            w_xi[n] = wide_t'($signed(i_x[n].im));
        end
    end

    // Inverse kernel: multiplying by +j maps (a, b) to (-b, a).
    always_comb begin
        w_yr[0] = w_xr[0] + w_xr[1] + w_xr[2] + w_xr[3];
        w_yi[0] = w_xi[0] + w_xi[1] + w_xi[2] + w_xi[3];
        w_yr[1] = w_xr[0] - w_xi[1] - w_xr[2] + w_xi[3];
        w_yi[1] = w_xi[0] + w_xr[1] - w_xi[2] - w_xr[3];
        w_yr[2] = w_xr[0] - w_xr[1] + w_xr[2] - w_xr[3];
        w_yi[2] = w_xi[0] - w_xi[1] + w_xi[2] - w_xi[3];
        w_yr[3] = w_xr[0] + w_xi[1] - w_xr[2] - w_xi[3];
        w_yi[3] = w_xi[0] - w_xr[1] - w_xi[2] + w_xr[3];
    end

    // Limit each result to BIT bits and flag any component that did not fit.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            o_y[k].re = limit(w_yr[k]);
            o_y[k].im = limit(w_yi[k]);
            o_ovf[k]  = out_of_range(w_yr[k]) | out_of_range(w_yi[k]);
        end
    end

endmodule

// File: rtl/fft_ibut_comp_ser.sv
// Streaming radix-4 inverse butterfly: collects 4 samples, outputs the 4 inverse-DFT bins serially.
// Latency: load one edge after the 4th accept; first result valid after that edge.
// Backpressure: output held while iREADY low; oREADY drops once the input bank is full and cannot be loaded.
// Limiting mode selected by FFT_IBUT_SAT_EN (saturate when defined, wrap otherwise).
module fft_ibut_comp_ser
    import fft_pkg::*;
(
    input  logic                  iCLK,
    input  logic                  iRESET,
    input  logic signed [BIT-1:0] iX_RE,
    input  logic signed [BIT-1:0] iX_IM,
    input  logic                  iVALID,
    output logic                  oREADY,
    output logic signed [BIT-1:0] oY_RE,
    output logic signed [BIT-1:0] oY_IM,
    output logic [1:0]            oIDX,
    output logic                  oVALID,
    input  logic                  iREADY,
    output logic                  oOVF
);

    sample_t    r_xbank [4];
    sample_t    r_ybank [4];
    logic [3:0] r_ovfbank;
    logic [1:0] r_wcnt;
    logic       r_full;
    logic       r_out_busy;
    logic [1:0] r_idx;

    sample_t    w_y [4];
    logic [3:0] w_ovf;
    logic       w_out_xfer;
    logic       w_load;
    logic       w_in_xfer;

    fft_ibut_core u_core (
        .i_x   (r_xbank),
        .o_y   (w_y),
        .o_ovf (w_ovf)
    );

    // Handshake: a load may reuse the cycle in which the last output bin leaves.
    assign w_out_xfer = r_out_busy & iREADY;
    assign w_load     = r_full & (~r_out_busy | (w_out_xfer & (r_idx == 2'd3)));
    assign oREADY     = ~r_full | w_load;
    assign w_in_xfer  = iVALID & oREADY;

    // Output view of the held bank; stays constant until idx advances or a load occurs.
    assign oVALID = r_out_busy;
    assign oIDX   = r_idx;
    assign oY_RE  = r_ybank[r_idx].re;
    assign oY_IM  = r_ybank[r_idx].im;
    assign oOVF   = r_ovfbank[r_idx];

    // Input side: fill the bank in order and mark it full after the 4th sample.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int n = 0; n < 4; n++) r_xbank[n] <= '0;
            r_wcnt <= 2'd0;
            r_full <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_xbank[r_wcnt] <= {iX_RE, iX_IM};
                r_wcnt          <= r_wcnt + 2'd1;
            end
            // full is never set while already full, so the two branches cannot collide.
            if (w_in_xfer && (r_wcnt == 2'd3))
                r_full <= 1'b1;
            else if (w_load)
                r_full <= 1'b0;
        end
    end

    // Output side: capture kernel results on load, then step through the four bins.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int k = 0; k < 4; k++) r_ybank[k] <= '0;
            r_ovfbank  <= 4'd0;
            r_out_busy <= 1'b0;
            r_idx      <= 2'd0;
        end else begin
            if (w_load) begin
                r_ybank    <= w_y;
                r_ovfbank  <= w_ovf;
                r_out_busy <= 1'b1;
                r_idx      <= 2'd0;
            end else if (w_out_xfer) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3)
                    r_out_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_ibut_comp_ser.sv
module tb_fft_ibut_comp_ser;
    import fft_pkg::*;

    logic                  iCLK = 1'b0;
    logic                  iRESET;
    logic signed [BIT-1:0] iX_RE, iX_IM;
    logic                  iVALID;
    logic                  oREADY;
    logic signed [BIT-1:0] oY_RE, oY_IM;
    logic [1:0]            oIDX;
    logic                  oVALID;
    logic                  iREADY;
    logic                  oOVF;

    fft_ibut_comp_ser dut (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iX_RE  (iX_RE),
        .iX_IM  (iX_IM),
        .iVALID (iVALID),
        .oREADY (oREADY),
        .oY_RE  (oY_RE),
        .oY_IM  (oY_IM),
        .oIDX   (oIDX),
        .oVALID (oVALID),
        .iREADY (iREADY),
        .oOVF   (oOVF)
    );

    always #5 iCLK = ~iCLK;

`ifdef FFT_IBUT_SAT_EN
    localparam int P160 = 65535;
    localparam int N160 = -65536;
    localparam int P120 = 65535;
`else
    localparam int P160 = 28928;
    localparam int N160 = -28928;
    localparam int P120 = -11072;
`endif

    typedef struct {
        int xre[4]; int xim[4];
        int yre[4]; int yim[4];
        bit ovf[4];
    } vec_t;

    typedef struct {
        int    re; int im; int idx; bit ovf; int tol;
        string tag;
    } exp_t;

    vec_t  vecs[7];
    exp_t  expq[$];
    exp_t  mon_e;
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;

    always @(posedge iCLK) cyc = cyc + 1;

    function automatic int absd(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Scoreboard: every output transfer is compared against the next expected bin.
    always @(negedge iCLK) begin
        if (iRESET && oVALID && iREADY) begin
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output actual idx=%0d re=%0d im=%0d", oIDX, oY_RE, oY_IM);
            end else begin
                mon_e = expq.pop_front();
                if (absd(int'(oY_RE), mon_e.re) > mon_e.tol || absd(int'(oY_IM), mon_e.im) > mon_e.tol ||
                    int'(oIDX) != mon_e.idx || oOVF != mon_e.ovf) begin
                    failures++;
                    $display("FAIL %s actual re=%0d im=%0d idx=%0d ovf=%0d required re=%0d im=%0d idx=%0d ovf=%0d tol=%0d",
                             mon_e.tag, oY_RE, oY_IM, oIDX, oOVF, mon_e.re, mon_e.im, mon_e.idx, mon_e.ovf, mon_e.tol);
                end
            end
        end
    end

    // Call only just after a rising edge; returns just after the accepting edge.
    task automatic send(input int re, input int im);
        int n;
        iX_RE  = BIT'(re);
        iX_IM  = BIT'(im);
        iVALID = 1'b1;
        n = 0;
        @(negedge iCLK);
        while (!oREADY && n < 200) begin
            n++;
            @(negedge iCLK);
        end
        if (!oREADY) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual oREADY=0 required oREADY=1");
        end
        @(posedge iCLK);
        #1 iVALID = 1'b0;
    endtask

    task automatic send_vec(input int v, input string tag);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.re = vecs[v].yre[k]; e.im = vecs[v].yim[k]; e.idx = k;
            e.ovf = vecs[v].ovf[k]; e.tol = 0; e.tag = tag;
            expq.push_back(e);
        end
        for (int n = 0; n < 4; n++) send(vecs[v].xre[n], vecs[v].xim[n]);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 500) begin
            @(posedge iCLK);
            n++;
        end
        #1;
        if (expq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual pending=%0d required pending=0", expq.size());
            expq.delete();
        end
    endtask

    function automatic int rnd4(input int v);
        return (v + 2) >>> 2;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int   xr[4], xi[4], fr[4], fi[4];
        int   t0;
        exp_t e;

        // Directed vectors with hand-computed results.
        vecs[0].xre = '{1000, 0, 0, 0};     vecs[0].xim = '{0, 0, 0, 0};
        vecs[0].yre = '{1000, 1000, 1000, 1000}; vecs[0].yim = '{0, 0, 0, 0};
        vecs[0].ovf = '{0, 0, 0, 0};
        vecs[1].xre = '{0, 0, 0, 0};        vecs[1].xim = '{0, 1000, 0, 0};
        vecs[1].yre = '{0, -1000, 0, 1000}; vecs[1].yim = '{1000, 0, -1000, 0};
        vecs[1].ovf = '{0, 0, 0, 0};
        vecs[2].xre = '{100, 10, 1, 3};     vecs[2].xim = '{200, 20, 2, 4};
        vecs[2].yre = '{114, 83, 88, 115};  vecs[2].yim = '{226, 205, 178, 191};
        vecs[2].ovf = '{0, 0, 0, 0};
        vecs[3].xre = '{1, 1, 1, 1};        vecs[3].xim = '{2, 2, 2, 2};
        vecs[3].yre = '{4, 0, 0, 0};        vecs[3].yim = '{8, 0, 0, 0};
        vecs[3].ovf = '{0, 0, 0, 0};
        vecs[4].xre = '{40000, 40000, 40000, 40000}; vecs[4].xim = '{0, 0, 0, 0};
        vecs[4].yre = '{P160, 0, 0, 0};     vecs[4].yim = '{0, 0, 0, 0};
        vecs[4].ovf = '{1, 0, 0, 0};
        vecs[5].xre = '{-40000, -40000, -40000, -40000}; vecs[5].xim = '{-40000, -40000, -40000, -40000};
        vecs[5].yre = '{N160, 0, 0, 0};     vecs[5].yim = '{N160, 0, 0, 0};
        vecs[5].ovf = '{1, 0, 0, 0};
        vecs[6].xre = '{60000, 0, 0, 0};    vecs[6].xim = '{0, -60000, 0, 0};
        vecs[6].yre = '{60000, P120, 60000, 0}; vecs[6].yim = '{-60000, 0, 60000, 0};
        vecs[6].ovf = '{0, 1, 0, 0};

        iRESET = 1'b0; iVALID = 1'b0; iREADY = 1'b1; iX_RE = '0; iX_IM = '0;
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_oVALID", oVALID, 0);
        chk("rst_oREADY", oREADY, 1);
        chk("rst_oIDX",   oIDX,   0);
        chk("rst_oOVF",   oOVF,   0);
        chk("rst_oY_RE",  oY_RE,  0);
        chk("rst_oY_IM",  oY_IM,  0);
        iRESET = 1'b1;
        @(posedge iCLK);
        #1;

        // Impulse with first-group latency.
        send_vec(0, "impulse");
        chk("lat_vld_after_4th", oVALID, 0);
        @(posedge iCLK);
        #1;
        chk("lat_vld_after_load", oVALID, 1);
        chk("lat_idx_after_load", oIDX, 0);
        wait_drain();

        // Remaining table vectors, back to back.
        for (int v = 1; v < 7; v++) send_vec(v, $sformatf("vec%0d", v));
        wait_drain();

        // Backpressure: stall at idx 1, fill the next group, then release.
        send_vec(2, "bp_groupA");
        for (int n = 0; n < 20; n++) begin
            @(posedge iCLK);
            #1;
            if (oVALID && oIDX == 2'd1) break;
        end
        chk("bp_reach_idx1", (oVALID && oIDX == 2'd1) ? 1 : 0, 1);
        iREADY = 1'b0;
        send_vec(3, "bp_groupB");
        chk("bp_oREADY_low", oREADY, 0);
        for (int c = 0; c < 6; c++) begin
            chk("bp_hold", (oVALID && oIDX == 2'd1 && int'(oY_RE) == vecs[2].yre[1] &&
                            int'(oY_IM) == vecs[2].yim[1] && !oOVF) ? 1 : 0, 1);
            chk("bp_oREADY_held_low", oREADY, 0);
            @(posedge iCLK);
            #1;
        end
        iREADY = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge iCLK);
            #1;
            chk("bp_no_gap", oVALID, 1);
            if (k == 2) chk("bp_oREADY_at_idx3", oREADY, 1);
            if (k == 3) chk("bp_idx_wrap", oIDX, 0);
        end
        wait_drain();

        // Round trip through a model of the forward scaled butterfly, continuous streaming.
        @(posedge iCLK);
        #1;
        t0 = cyc;
        for (int g = 0; g < 30; g++) begin
            for (int n = 0; n < 4; n++) begin
                xr[n] = int'($urandom_range(65536)) - 32768;
                xi[n] = int'($urandom_range(65536)) - 32768;
            end
            fr[0] = rnd4(xr[0] + xr[1] + xr[2] + xr[3]);
            fi[0] = rnd4(xi[0] + xi[1] + xi[2] + xi[3]);
            fr[1] = rnd4(xr[0] + xi[1] - xr[2] - xi[3]);
            fi[1] = rnd4(xi[0] - xr[1] - xi[2] + xr[3]);
            fr[2] = rnd4(xr[0] - xr[1] + xr[2] - xr[3]);
            fi[2] = rnd4(xi[0] - xi[1] + xi[2] - xi[3]);
            fr[3] = rnd4(xr[0] - xi[1] - xr[2] + xi[3]);
            fi[3] = rnd4(xi[0] + xr[1] - xi[2] - xr[3]);
            for (int n = 0; n < 4; n++) begin
                e.re = xr[n]; e.im = xi[n]; e.idx = n; e.ovf = 1'b0; e.tol = 2; e.tag = "roundtrip";
                expq.push_back(e);
            end
            for (int n = 0; n < 4; n++) send(fr[n], fi[n]);
        end
        wait_drain();
        chk("throughput_cycles_ok", (cyc - t0 <= 126) ? 1 : 0, 1);

        // Reset with an undrained output group and a partial input group.
        iREADY = 1'b0;
        for (int n = 0; n < 4; n++) send(vecs[2].xre[n], vecs[2].xim[n]);
        send(5, 5);
        send(6, 6);
        chk("mid_busy_before_rst", oVALID, 1);
        iRESET = 1'b0;
        #2;
        chk("mid_rst_oVALID", oVALID, 0);
        chk("mid_rst_oREADY", oREADY, 1);
        chk("mid_rst_oIDX",   oIDX,   0);
        chk("mid_rst_oOVF",   oOVF,   0);
        chk("mid_rst_oY_RE",  oY_RE,  0);
        chk("mid_rst_oY_IM",  oY_IM,  0);
        expq.delete();
        @(posedge iCLK);
        #1;
        iRESET = 1'b1;
        iREADY = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;
        chk("mid_no_stale_output", oVALID, 0);
        send_vec(1, "after_reset");
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
